fpga_cfg_loader: RTL and testbench
==================================

FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 SHALL have parameter FPGA_WIDTH, default 5, fabric columns.
REQ-002 SHALL have parameter FPGA_HEIGHT, default 5, fabric rows.
REQ-003 SHALL have parameter DW, default 8, stream word width (8..32).
REQ-004 SHALL derive: BRB_BITS=36*W*H, BSB_BITS=108*(W-1)*(H-1), LB_BITS=5*(W-1)*(H-1), IO_BITS=6*W, TOTAL=BRB+BSB+LB+4*IO, NWORDS=ceil(TOTAL/DW) (5x5, DW=8: 2828 bits, 354 words).
REQ-005 SHALL have one clock and an asynchronous active-low reset, with ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin load session
- din  in  DW  stream word
- din_valid  in  1  word valid
- din_ready  out  1  loader accepts word
- brbselect  out  BRB_BITS  active config
- bsbselect  out  BSB_BITS  active config
- lbselect  out  LB_BITS  active config
- leftioselect / rightioselect / topioselect / bottomioselect  out  IO_BITS each  active config
- busy  out  1  session in progress
- cfg_done  out  1  active config committed and valid
- cfg_error  out  1  last session failed checksum

Function
REQ-006 SHALL implement states IDLE, SYNC, LOAD, CHECK, COMMIT, ERROR.
REQ-007 Word transfer SHALL occur only on a clk edge with din_valid&&din_ready; din_ready SHALL be 1 exactly in SYNC, LOAD and CHECK.
REQ-008 IDLE: start -> SYNC, clear shadow, word counter and checksum, deassert cfg_done/cfg_error.
REQ-009 SYNC: word equal to SYNC pattern (DW'hA5 replicated/truncated to DW) -> LOAD; any other word SHALL be discarded, state held.
REQ-010 LOAD: word k (0..NWORDS-1) SHALL be written to shadow bits [k*DW +: DW] of concatenation {bottom,top,right,left,lb,bsb,brb} (brb at LSB); pad bits beyond TOTAL SHALL be dropped; checksum ^= word.
REQ-011 After word NWORDS-1 transfers -> CHECK.
REQ-012 CHECK: transferred word == checksum -> COMMIT; otherwise -> ERROR.
REQ-013 COMMIT SHALL last one cycle: copy shadow to active outputs in that cycle, set cfg_done, -> IDLE.
REQ-014 ERROR SHALL last one cycle: set cfg_error, leave active outputs unchanged, -> IDLE.
REQ-015 Active outputs SHALL change only in COMMIT or reset; never mid-session.
REQ-016 start while busy SHALL be ignored; start in same cycle as COMMIT/ERROR SHALL be ignored.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 cfg_done/cfg_error SHALL hold until next accepted start or reset; never both 1.
REQ-019 din_valid low SHALL stall without state or counter change, for any duration.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, all select outputs, shadow, counter, checksum to 0, busy/cfg_done/cfg_error/din_ready to 0.
REQ-021 Reset mid-session SHALL discard partial load; next session SHALL start from word 0.
REQ-022 Release SHALL be synchronous to clk; first start accepted on the first edge after release.

Structure
REQ-023 Shared package fpga_cfg_pkg SHALL hold state enum, SYNC constant and bit-count functions of (W,H).
REQ-024 Sub-module cfg_shadow_bank SHALL hold shadow and active registers with word-write and commit ports.
REQ-025 Word-index to bit-offset SHALL use a registered counter of width clog2(NWORDS+1); no multipliers at runtime beyond constant DW scaling.

Verification
REQ-026 5x5, DW=8: start, 0xA5, 354 words with only word 0 = 0x02 (brbselect[1]=1 set), checksum 0x02 -> after COMMIT brbselect==900'h2, others 0, cfg_done=1.
REQ-027 Same stream with checksum 0x03 -> cfg_error=1, all selects remain previous values (0 after reset).
REQ-028 Words 0x00,0x13,0xA5 then valid load -> first two discarded, load identical to REQ-026 result.
REQ-029 rst_n low after word 200, then full valid session with word 353 = 0x0F (checksum 0x0F) -> bottomioselect upper bits set only from word 353 lower nibble (pad dropped), brb unchanged 0.
REQ-030 din_valid toggled randomly (50%) during load -> result identical to continuous stream; start pulses mid-load have no effect.
REQ-031 W=4,H=3,DW=16 run -> NWORDS=ceil((432+648+30+96)/16)=76, commit correct.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration loader: FSM states, the
// stream sync pattern and the fabric bit-count formulas.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOAD,
    ST_CHECK,
    ST_COMMIT,
    ST_ERROR
  } state_e;

  // Narrower streams take the low DW bits of this pattern.
  localparam logic [31:0] SYNC_PAT32 = 32'hA5A5_A5A5;

  function automatic int brb_bits(input int w, input int h);
    return 36 * w * h;
  endfunction

  function automatic int bsb_bits(input int w, input int h);
    return 108 * (w - 1) * (h - 1);
  endfunction

  function automatic int lb_bits(input int w, input int h);
    return 5 * (w - 1) * (h - 1);
  endfunction

  function automatic int io_bits(input int w);
    return 6 * w;
  endfunction

  function automatic int total_bits(input int w, input int h);
    return brb_bits(w, h) + bsb_bits(w, h) + lb_bits(w, h) + 4 * io_bits(w);
  endfunction

  function automatic int nwords(input int w, input int h, input int dw);
    return (total_bits(w, h) + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_shadow_bank.sv
// Shadow and active configuration storage. Words land in the shadow copy as
// they stream in; the active copy only changes on a one-cycle commit.
module cfg_shadow_bank #(
  parameter int TOTAL  = 2828,
  parameter int DW     = 8,
  parameter int IW     = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [IW-1:0]    wr_idx_i,
  input  logic [DW-1:0]    wr_data_i,
  input  logic             commit_i,
  output logic [TOTAL-1:0] active_o
);

  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [TOTAL-1:0] active_q, active_d;
  int               base;

  always_comb begin
    shadow_d = shadow_q;
    base     = int'(wr_idx_i) * DW;
    if (clr_i) begin
      shadow_d = '0;
    end else if (wr_en_i) begin
      // Bits of the last word that fall past TOTAL are padding and dropped.
      for (int j = 0; j < DW; j++) begin
        if (base + j < TOTAL) shadow_d[base + j] = wr_data_i[j];
      end
    end
  end

  always_comb begin
    active_d = commit_i ? shadow_q : active_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Streams a checksummed configuration image into a shadow bank and commits it
// to the fabric select outputs only when the whole image verifies.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int FPGA_WIDTH  = 5,
  parameter int FPGA_HEIGHT = 5,
  parameter int DW          = 8,
  localparam int BRB_BITS   = brb_bits(FPGA_WIDTH, FPGA_HEIGHT),
  localparam int BSB_BITS   = bsb_bits(FPGA_WIDTH, FPGA_HEIGHT),
  localparam int LB_BITS    = lb_bits(FPGA_WIDTH, FPGA_HEIGHT),
  localparam int IO_BITS    = io_bits(FPGA_WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DW-1:0]       din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [BRB_BITS-1:0] brbselect,
  output logic [BSB_BITS-1:0] bsbselect,
  output logic [LB_BITS-1:0]  lbselect,
  output logic [IO_BITS-1:0]  leftioselect,
  output logic [IO_BITS-1:0]  rightioselect,
  output logic [IO_BITS-1:0]  topioselect,
  output logic [IO_BITS-1:0]  bottomioselect,
  output logic                busy,
  output logic                cfg_done,
  output logic                cfg_error
);

  localparam int TOTAL  = total_bits(FPGA_WIDTH, FPGA_HEIGHT);
  localparam int NWORDS = nwords(FPGA_WIDTH, FPGA_HEIGHT, DW);
  localparam int CW     = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NWORDS - 1);
  localparam logic [DW-1:0] SYNC_WORD = SYNC_PAT32[DW-1:0];
  localparam int OFF_BSB = BRB_BITS;
  localparam int OFF_LB  = OFF_BSB + BSB_BITS;
  localparam int OFF_IO  = OFF_LB + LB_BITS;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   csum_q, csum_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            xfer;
  logic            sh_clr, sh_wr, sh_commit;
  logic [TOTAL-1:0] active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SYNC;
          cnt_d   = '0;
          csum_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_SYNC: begin
        if (xfer && din == SYNC_WORD) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (xfer) begin
          csum_d = csum_q ^ din;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (xfer) state_d = (din == csum_q) ? ST_COMMIT : ST_ERROR;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_ERROR: begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    din_ready = (state_q == ST_SYNC) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
    busy      = (state_q != ST_IDLE);
    xfer      = din_valid && din_ready;
    sh_clr    = (state_q == ST_IDLE) && start;
    sh_wr     = (state_q == ST_LOAD) && xfer;
    sh_commit = (state_q == ST_COMMIT);
  end

  cfg_shadow_bank #(
    .TOTAL (TOTAL),
    .DW    (DW),
    .IW    (CW)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (sh_clr),
    .wr_en_i   (sh_wr),
    .wr_idx_i  (cnt_q),
    .wr_data_i (din),
    .commit_i  (sh_commit),
    .active_o  (active)
  );

  // Image layout, LSB first: brb, bsb, lb, left, right, top, bottom.
  assign brbselect      = active[BRB_BITS-1:0];
  assign bsbselect      = active[OFF_BSB +: BSB_BITS];
  assign lbselect       = active[OFF_LB +: LB_BITS];
  assign leftioselect   = active[OFF_IO +: IO_BITS];
  assign rightioselect  = active[OFF_IO + IO_BITS +: IO_BITS];
  assign topioselect    = active[OFF_IO + 2 * IO_BITS +: IO_BITS];
  assign bottomioselect = active[OFF_IO + 3 * IO_BITS +: IO_BITS];
  assign cfg_done       = done_q;
  assign cfg_error      = err_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader: a 5x5/DW=8 instance and a 4x3/DW=16
// instance, with expected session results queued and checked as sessions end.
module tb_fpga_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, din_valid;
  logic [7:0] din;
  logic din_ready, busy, cfg_done, cfg_error;
  logic [899:0]  brb;
  logic [1727:0] bsb;
  logic [79:0]   lb;
  logic [29:0]   lio, rio, tio, bio;

  logic start2, din_valid2;
  logic [15:0] din2;
  logic din_ready2, busy2, cfg_done2, cfg_error2;
  logic [431:0] brb2;
  logic [647:0] bsb2;
  logic [29:0]  lb2;
  logic [23:0]  lio2, rio2, tio2, bio2;

  fpga_cfg_loader #(.FPGA_WIDTH(5), .FPGA_HEIGHT(5), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .brbselect(brb), .bsbselect(bsb), .lbselect(lb),
    .leftioselect(lio), .rightioselect(rio), .topioselect(tio), .bottomioselect(bio),
    .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  fpga_cfg_loader #(.FPGA_WIDTH(4), .FPGA_HEIGHT(3), .DW(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .din(din2), .din_valid(din_valid2),
    .din_ready(din_ready2), .brbselect(brb2), .bsbselect(bsb2), .lbselect(lb2),
    .leftioselect(lio2), .rightioselect(rio2), .topioselect(tio2), .bottomioselect(bio2),
    .busy(busy2), .cfg_done(cfg_done2), .cfg_error(cfg_error2)
  );

  typedef struct packed {
    logic done; logic err;
    logic [899:0] brb; logic [1727:0] bsb; logic [79:0] lb;
    logic [29:0] l; logic [29:0] r; logic [29:0] t; logic [29:0] b;
  } exp1_t;

  typedef struct packed {
    logic done; logic err;
    logic [431:0] brb; logic [647:0] bsb; logic [29:0] lb;
    logic [23:0] l; logic [23:0] r; logic [23:0] t; logic [23:0] b;
  } exp2_t;

  exp1_t q1[$];
  exp2_t q2[$];
  exp1_t e1, x1;
  exp2_t e2, x2;

  logic [7:0]  words1[354];
  logic [15:0] words2[76];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [1727:0] act, input logic [1727:0] exp);
    int fd;
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      fd = -1;
      for (int i = 1727; i >= 0; i--) if (act[i] !== exp[i]) fd = i;
      $display("FAIL %s: actual ones=%0d low64=%h, required ones=%0d low64=%h, first differing bit %0d",
               nm, $countones(act), act[63:0], $countones(exp), exp[63:0], fd);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    chk(nm, 1728'(a), 1728'(e));
  endtask

  // Session-end monitors: a falling busy with reset high marks a finished session.
  bit bp1 = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bp1 && !busy) begin
      chk1("sb1_has_entry", q1.size() != 0, 1'b1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk1("cfg_done", cfg_done, e1.done);
        chk1("cfg_error", cfg_error, e1.err);
        chk("brbselect", 1728'(brb), 1728'(e1.brb));
        chk("bsbselect", bsb, e1.bsb);
        chk("lbselect", 1728'(lb), 1728'(e1.lb));
        chk("leftioselect", 1728'(lio), 1728'(e1.l));
        chk("rightioselect", 1728'(rio), 1728'(e1.r));
        chk("topioselect", 1728'(tio), 1728'(e1.t));
        chk("bottomioselect", 1728'(bio), 1728'(e1.b));
      end
    end
    bp1 = rst_n && busy;
  end

  bit bp2 = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bp2 && !busy2) begin
      chk1("sb2_has_entry", q2.size() != 0, 1'b1);
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        chk1("w4h3_cfg_done", cfg_done2, e2.done);
        chk1("w4h3_cfg_error", cfg_error2, e2.err);
        chk("w4h3_brb", 1728'(brb2), 1728'(e2.brb));
        chk("w4h3_bsb", 1728'(bsb2), 1728'(e2.bsb));
        chk("w4h3_lb", 1728'(lb2), 1728'(e2.lb));
        chk("w4h3_left", 1728'(lio2), 1728'(e2.l));
        chk("w4h3_right", 1728'(rio2), 1728'(e2.r));
        chk("w4h3_top", 1728'(tio2), 1728'(e2.t));
        chk("w4h3_bottom", 1728'(bio2), 1728'(e2.b));
      end
    end
    bp2 = rst_n && busy2;
  end

  task automatic send_word(input logic [7:0] w, input bit rnd, input bit noise);
    int guard;
    if (rnd) begin
      while ($urandom_range(0, 1) == 1) begin
        din_valid = 1'b0;
        din = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    if (noise) start = 1'($urandom_range(0, 1));
    din = w;
    din_valid = 1'b1;
    guard = 0;
    while (!din_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!din_ready) chk1("din_ready_timeout", din_ready, 1'b1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic send_word2(input logic [15:0] w);
    int guard;
    din2 = w;
    din_valid2 = 1'b1;
    guard = 0;
    while (!din_ready2 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!din_ready2) chk1("w4h3_din_ready_timeout", din_ready2, 1'b1);
    @(posedge clk); #1;
    din_valid2 = 1'b0;
  endtask

  task automatic begin_session();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk1("busy_after_start", busy, 1'b1);
    chk1("done_cleared_on_start", cfg_done, 1'b0);
    chk1("error_cleared_on_start", cfg_error, 1'b0);
  endtask

  task automatic session1(input logic [7:0] cs, input bit rnd, input bit noise,
                          input bit garbage, input bit start_end);
    begin_session();
    if (garbage) begin
      send_word(8'h00, rnd, 1'b0);
      send_word(8'h13, rnd, 1'b0);
    end
    send_word(8'hA5, rnd, 1'b0);
    for (int k = 0; k < 354; k++) send_word(words1[k], rnd, noise);
    send_word(cs, rnd, 1'b0);
    if (start_end) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk1("idle_after_session", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic clear_words1();
    for (int k = 0; k < 354; k++) words1[k] = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; din_valid = 1'b0; din = 8'h00;
    start2 = 1'b0; din_valid2 = 1'b0; din2 = 16'h0000;
    #12;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_din_ready", din_ready, 1'b0);
    chk1("rst_cfg_done", cfg_done, 1'b0);
    chk1("rst_cfg_error", cfg_error, 1'b0);
    chk("rst_brbselect", 1728'(brb), 1728'(0));
    chk1("rst_w4h3_busy", busy2, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bad checksum straight after reset: error, selects stay zero.
    clear_words1();
    words1[0] = 8'h02;
    x1 = '0; x1.err = 1'b1;
    q1.push_back(x1);
    session1(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

    // Good checksum: brbselect[1] set; start during COMMIT must be ignored.
    x1 = '0; x1.done = 1'b1; x1.brb = 900'h2;
    q1.push_back(x1);
    session1(8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

    // Non-sync words before the sync word are discarded.
    q1.push_back(x1);
    session1(8'h02, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset after word 200 of a partial load.
    begin_session();
    send_word(8'hA5, 1'b0, 1'b0);
    for (int k = 0; k <= 200; k++) send_word(words1[k], 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_din_ready", din_ready, 1'b0);
    chk1("midrst_cfg_done", cfg_done, 1'b0);
    chk("midrst_brbselect", 1728'(brb), 1728'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_words1();
    words1[353] = 8'h0F;
    x1 = '0; x1.done = 1'b1; x1.b = 30'h3C00_0000;
    q1.push_back(x1);
    session1(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);

    // Multi-word pattern, continuous then with random valid gaps and start noise.
    clear_words1();
    words1[0] = 8'h02; words1[100] = 8'h5A; words1[353] = 8'h0F;
    x1 = '0; x1.done = 1'b1; x1.b = 30'h3C00_0000;
    x1.brb = 900'h2;
    x1.brb[807:800] = 8'h5A;
    q1.push_back(x1);
    session1(8'h57, 1'b0, 1'b0, 1'b0, 1'b0);
    q1.push_back(x1);
    session1(8'h57, 1'b1, 1'b1, 1'b0, 1'b0);

    // 4x3 fabric, 16-bit stream, 76 words; last word keeps its low 6 bits.
    for (int k = 0; k < 76; k++) words2[k] = 16'h0000;
    words2[0] = 16'h1234; words2[75] = 16'hFFFF;
    x2 = '0; x2.done = 1'b1; x2.brb = 432'h1234; x2.b = 24'hFC_0000;
    q2.push_back(x2);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk1("w4h3_busy_after_start", busy2, 1'b1);
    send_word2(16'hA5A5);
    for (int k = 0; k < 76; k++) send_word2(words2[k]);
    send_word2(16'hEDCB);
    repeat (3) @(posedge clk);
    #1;

    chk("sb1_drained", 1728'(q1.size()), 1728'(0));
    chk("sb2_drained", 1728'(q2.size()), 1728'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
